chip8_display_scan: RTL and testbench
=====================================

# chip8_display_scan

Raster scan-out stage downstream of the CHIP-8 CPU. Consumes the CPU's 2048-bit `display` framebuffer (64×32, 1 bpp) and produces a scaled, centred 640×480 VGA-style pixel stream with sync signals. The framebuffer is copied into a shadow register once per frame at the start of vertical blanking, so CPU writes never tear a visible frame. A per-frame tick is exported for 60 Hz timer logic.

## Interface
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FP`, `H_SYNC`, `H_BP`, defaults 16 / 96 / 48: horizontal porch and sync widths.
- `V_ACTIVE`, default 480: visible lines per frame.
- `V_FP`, `V_SYNC`, `V_BP`, defaults 10 / 2 / 33: vertical porch and sync widths.
- `SCALE`, default 10: output pixels per framebuffer pixel, in both axes.
- `V_OFFSET`, default 80: first active line of the framebuffer window.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `pix_en` in 1: pixel-clock enable; counters and outputs advance only on `clk` edges where it is 1.
- `display` in 2048: CPU framebuffer; bit index = y*64 + x, bit 0 = top-left.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `video_on` out 1: high inside the H_ACTIVE×V_ACTIVE region.
- `pixel` out 1: lit-pixel output, 0 whenever `video_on` = 0.
- `frame_tick` out 1: one-`clk` pulse per frame at the start of vertical blanking.

## Operation
- Counters: `h` runs 0..H_TOTAL-1 and `v` runs 0..V_TOTAL-1, where H_TOTAL = 800 and V_TOTAL = 525 by default. `h` wraps to 0 and increments `v`; `v` wraps to 0 after V_TOTAL-1. Both advance only when `pix_en` = 1.
- Sync: `hsync` = 0 iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, i.e. h 656..751. `vsync` = 0 iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, i.e. v 490..491.
- `video_on` = (h < H_ACTIVE) && (v < V_ACTIVE).
- Window: V_OFFSET ≤ v < V_OFFSET+32*SCALE (lines 80..399). Inside the window, x = h/SCALE and y = (v−V_OFFSET)/SCALE. `pixel` = shadow[y*64+x] && video_on. Outside the window `pixel` = 0.
- The x/y derivation uses sub-pixel counters (0..SCALE-1). No dividers or multipliers in the datapath beyond constant shifts.
- Shadow load: on a `pix_en` edge with h = 0 and v = V_ACTIVE, `shadow` ← `display`. On the same edge `frame_tick` is set; it clears on the next `clk` edge regardless of `pix_en`.
- `display` changes at any other time have no visible effect until the next shadow load.
- Reset, including mid-frame: h = v = 0, shadow = 0, `hsync` = `vsync` = 1, `video_on` = `pixel` = `frame_tick` = 0. Scanning restarts from the top-left on the first `pix_en` edge after release. No partial frame is resumed.

## Timing
- All outputs are registered. On a `pix_en` = 1 edge, outputs take the decode of the current (h, v), then the counters advance. Outputs therefore lag the counters by one `pix_en` step.
- `pix_en` = 0 holds every counter, the shadow and all outputs except `frame_tick`, which still self-clears after one `clk`.
- With `pix_en` held at 1: line period is 800 clk and frame period is 420000 clk. `frame_tick` occurs exactly once per frame.
- There is no handshake with the CPU. `display` is sampled only on the shadow-load edge and must be stable at that edge; the CPU clock domain equals `clk`.

## Test plan
- Reset values: assert `reset` asynchronously mid-line → all outputs at reset values immediately, without waiting for a `clk` edge. After release with `pix_en` = 1, the first `hsync` low starts 656 edges later.
- Sync geometry, `pix_en` = 1: `hsync` low for exactly 96 cycles every 800; `vsync` low for exactly 2 lines (1600 cycles) every 420000; `video_on` high 640 cycles per active line.
- Pixel mapping: `display` = only bit 0 set, held through a `frame_tick` → in the next frame `pixel` = 1 exactly for output positions h 0..9, v 80..89 (100 pixels), 0 elsewhere. Repeat with only bit 2047 set → h 630..639, v 390..399.
- Tear-free: set `display` = all ones at v = 200 → `pixel` unchanged for the rest of the frame. The whole window (lines 80..399) is lit after the next `frame_tick`; lines 0..79 and 400..479 stay 0.
- Enable gating: `pix_en` toggling 1,0,1,0 → all counts double in `clk` cycles; `frame_tick` width stays 1 `clk`.
- CPU integration: run a 00E0 then DXYN loop on the CPU → `pixel` (0,0) toggles once per frame only when a DXYN executes between shadow loads.

Source files
------------

// File: rtl/chip8_display_scan_if.sv
// Pixel-stream bundle between the CHIP-8 framebuffer source and the raster scan-out stage.
interface chip8_display_scan_if;
  logic          pix_en;
  logic [2047:0] display;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic          pixel;
  logic          frame_tick;

  // Source side: supplies pixel-clock enable and framebuffer, observes the raster.
  modport master (
    output pix_en,
    output display,
    input  hsync,
    input  vsync,
    input  video_on,
    input  pixel,
    input  frame_tick
  );

  // Scan-out side.
  modport slave (
    input  pix_en,
    input  display,
    output hsync,
    output vsync,
    output video_on,
    output pixel,
    output frame_tick
  );
endinterface

// File: rtl/chip8_display_scan.sv
// CHIP-8 raster scan-out: 64x32 1bpp framebuffer scaled into a VGA-style timing grid.
// The framebuffer is latched into a shadow copy at the start of vertical blanking so a
// frame is never torn by CPU writes; x/y are tracked by sub-pixel counters (no dividers).
module chip8_display_scan #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SCALE    = 10,
  parameter int V_OFFSET = 80
) (
  input  logic                 clk,
  input  logic                 reset,
  chip8_display_scan_if.slave  scan
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int XW      = $clog2(H_TOTAL / SCALE + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_S  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_S  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] WIN_TOP  = VW'(V_OFFSET);
  localparam logic [VW-1:0] WIN_END  = VW'(V_OFFSET + 32 * SCALE);
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
  localparam logic [XW-1:0] X_COLS   = XW'(64);

  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic [SW-1:0]   sx_q, sx_d, sy_q, sy_d;
  logic [XW-1:0]   x_q, x_d;
  logic [4:0]      y_q, y_d;
  logic [2047:0]   shadow_q;
  logic            hsync_q, vsync_q, video_on_q, pixel_q, frame_tick_q;

  logic            h_end, v_end, load;
  logic            hs_n, vs_n, von, in_win, pix;
  logic [10:0]     pix_idx;

  // Counter advance and decode of the current (h, v) position.
  always_comb begin
    h_end = (h_q == H_LAST);
    v_end = (v_q == V_LAST);
    h_d   = h_end ? '0 : h_q + HW'(1);
    v_d   = v_q;
    if (h_end) v_d = v_end ? '0 : v_q + VW'(1);

    // Horizontal sub-pixel counter restarts at the left edge of every line.
    sx_d = sx_q;
    x_d  = x_q;
    if (h_end) begin
      sx_d = '0;
      x_d  = '0;
    end else if (sx_q == SUB_LAST) begin
      sx_d = '0;
      x_d  = x_q + XW'(1);
    end else begin
      sx_d = sx_q + SW'(1);
    end

    // Vertical sub-pixel counter steps once per line and restarts at the window top.
    sy_d = sy_q;
    y_d  = y_q;
    if (h_end) begin
      if (v_d == WIN_TOP) begin
        sy_d = '0;
        y_d  = '0;
      end else if (sy_q == SUB_LAST) begin
        sy_d = '0;
        y_d  = y_q + 5'(1);
      end else begin
        sy_d = sy_q + SW'(1);
      end
    end

    hs_n    = !((h_q >= HS_START) && (h_q < HS_END));
    vs_n    = !((v_q >= VS_START) && (v_q < VS_END));
    von     = (h_q < H_ACT_S) && (v_q < V_ACT_S);
    in_win  = (v_q >= WIN_TOP) && (v_q < WIN_END);
    pix_idx = {y_q, x_q[5:0]};
    pix     = von && in_win && (x_q < X_COLS) && shadow_q[pix_idx];
    load    = (h_q == '0) && (v_q == V_ACT_S);
  end

  // Scan counters and registered raster outputs; frame_tick self-clears every clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q          <= '0;
      v_q          <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b0;
      pixel_q      <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= 1'b0;
      if (scan.pix_en) begin
        h_q          <= h_d;
        v_q          <= v_d;
        sx_q         <= sx_d;
        sy_q         <= sy_d;
        x_q          <= x_d;
        y_q          <= y_d;
        hsync_q      <= hs_n;
        vsync_q      <= vs_n;
        video_on_q   <= von;
        pixel_q      <= pix;
        frame_tick_q <= load;
      end
    end
  end

  // Shadow framebuffer: captured once per frame at the start of vertical blanking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) shadow_q <= '0;
    else if (scan.pix_en && load) shadow_q <= scan.display;
  end

  assign scan.hsync      = hsync_q;
  assign scan.vsync      = vsync_q;
  assign scan.video_on   = video_on_q;
  assign scan.pixel      = pixel_q;
  assign scan.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_chip8_display_scan.sv
// Randomized bench for chip8_display_scan against a position/arithmetic reference model,
// using a reduced raster (SCALE 2) so several full frames fit in a short run.
module tb_chip8_display_scan;

  localparam int SC  = 2;
  localparam int HA  = 128;
  localparam int HFP = 4;
  localparam int HSY = 8;
  localparam int HBP = 4;
  localparam int VA  = 72;
  localparam int VFP = 2;
  localparam int VSY = 2;
  localparam int VBP = 3;
  localparam int VO  = 4;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;

  logic clk = 1'b0;
  logic reset = 1'b0;

  chip8_display_scan_if sif();

  chip8_display_scan #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SCALE(SC), .V_OFFSET(VO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .scan  (sif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int frames  = 0;
  int dut_ticks = 0;

  // reference model state
  int            mh, mv;
  logic [2047:0] msh;
  logic          e_hs, e_vs, e_von, e_pix, e_ft;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d h=%0d v=%0d got=%0h exp=%0h", tag, cyc, mh, mv, act, exp);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; msh = '0;
    e_hs = 1'b1; e_vs = 1'b1; e_von = 1'b0; e_pix = 1'b0; e_ft = 1'b0;
  endtask

  task automatic model_step(input logic pe);
    int idx;
    e_ft = 1'b0;
    if (pe) begin
      e_hs  = !((mh >= HA + HFP) && (mh < HA + HFP + HSY));
      e_vs  = !((mv >= VA + VFP) && (mv < VA + VFP + VSY));
      e_von = (mh < HA) && (mv < VA);
      e_pix = 1'b0;
      if (e_von && mv >= VO && mv < VO + 32 * SC) begin
        idx   = ((mv - VO) / SC) * 64 + mh / SC;
        e_pix = msh[idx];
      end
      if (mh == 0 && mv == VA) begin
        msh  = sif.display;
        e_ft = 1'b1;
        frames++;
      end
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end
    end
  endtask

  task automatic check_all();
    check_val("hsync",      32'(sif.hsync),      32'(e_hs));
    check_val("vsync",      32'(sif.vsync),      32'(e_vs));
    check_val("video_on",   32'(sif.video_on),   32'(e_von));
    check_val("pixel",      32'(sif.pixel),      32'(e_pix));
    check_val("frame_tick", 32'(sif.frame_tick), 32'(e_ft));
  endtask

  task automatic check_reset_outputs();
    check_val("rst_hsync",      32'(sif.hsync),      32'd1);
    check_val("rst_vsync",      32'(sif.vsync),      32'd1);
    check_val("rst_video_on",   32'(sif.video_on),   32'd0);
    check_val("rst_pixel",      32'(sif.pixel),      32'd0);
    check_val("rst_frame_tick", 32'(sif.frame_tick), 32'd0);
  endtask

  // one clk: drive enable, advance the model on the edge, compare #1 after
  task automatic step(input logic pe);
    sif.pix_en = pe;
    @(posedge clk);
    cyc++;
    if (reset) model_reset();
    else model_step(pe);
    #1;
    if (sif.frame_tick) dut_ticks++;
    check_all();
    #1;
  endtask

  task automatic random_display();
    for (int w = 0; w < 64; w++) sif.display[w*32 +: 32] = $urandom();
  endtask

  task automatic run_until(input int f, input int line);
    while (!(frames == f && mv == line)) begin
      if (cyc > 90000) begin
        check_val("run_bound", 32'(cyc), 32'd0);
        return;
      end
      step(1'b1);
    end
  endtask

  initial begin
    sif.pix_en  = 1'b0;
    sif.display = '0;
    model_reset();
    #1 reset = 1'b1;
    #1 check_reset_outputs();

    repeat (3) step(1'b1);
    reset = 1'b0;

    // frame 1 shows a lone top-left pixel
    sif.display = '0;
    sif.display[0] = 1'b1;
    run_until(1, 20);

    // change during display: must not tear; frame 2 shows bottom-right only
    sif.display = '0;
    sif.display[2047] = 1'b1;
    run_until(2, 30);

    // all ones mid-frame; whole window lit only in frame 3
    sif.display = '1;
    run_until(3, 10);

    // pix_en alternating 1,0,1,0
    for (int i = 0; i < 2000; i++) step(i % 2 == 0);

    // random enable gating with random framebuffer updates
    for (int i = 0; i < 16000; i++) begin
      if ($urandom_range(0, 299) == 0) random_display();
      step($urandom_range(0, 3) != 0);
    end

    // asynchronous reset mid-line, checked before any clk edge
    reset = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    #1;
    step(1'b1);
    step(1'b0);
    reset = 1'b0;

    random_display();
    for (int i = 0; i < 13000; i++) step(1'b1);

    check_val("tick_count", 32'(dut_ticks), 32'(frames));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
